pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core. Drives write-enable/flush/bubble controls of PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three hazard classes:
  - load-use stalls;
  - taken-branch redirect and flush, with the branch resolved in MEM from the EX/MEM branch and zero outputs;
  - data-memory wait states, with a timeout watchdog.
- Keeps saturating performance counters for stall, flush and wait cycles.

Parameters:
- TIMEOUT, 16: consecutive not-ready memory cycles that trip the error state (legal range 2..2^TO_W-1).
- TO_W, 8: width of the wait timer.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- idex_memread  in  1  ID/EX instruction is a load
- idex_rd  in  5  ID/EX destination register
- ifid_rs1  in  5  IF/ID source register 1
- ifid_rs2  in  5  IF/ID source register 2
- exmem_branch  in  1  EX/MEM Branch control
- exmem_zero  in  1  EX/MEM ALU zero flag
- exmem_memread  in  1  EX/MEM Memread
- exmem_memwrite  in  1  EX/MEM Memwrite
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_write  out  1  ID/EX load enable
- exmem_write  out  1  EX/MEM load enable
- idex_bubble  out  1  ID/EX captures all-zero controls
- ifid_flush  out  1  IF/ID clears
- idex_flush  out  1  ID/EX clears
- exmem_flush  out  1  drives the EX/MEM flush input
- pc_src  out  1  PC takes the branch target
- mem_err  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  taken-branch flush events
- wait_cnt  out  CNT_W  memory wait cycles

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-low. While reset=0 at an edge:
  - state becomes RUN;
  - timer and all counters become 0;
  - mem_err becomes 0.
- Control outputs are combinational from state and inputs.
- During any cycle with reset=0, the design forces all control outputs low, i.e. write enables=0, flush/bubble=0 and pc_src=0.
- Derived signals:
  - mem_req = exmem_memread | exmem_memwrite
  - mem_stall = mem_req & ~dmem_ready
  - br_taken = exmem_branch & exmem_zero
  - lu_hazard = idex_memread & (idex_rd != 0) & (idex_rd == ifid_rs1 | idex_rd == ifid_rs2)
- States: RUN, MEM_WAIT, ERROR.
- Output priority in RUN/MEM_WAIT (first match wins):
  1. mem_stall: all four write enables=0, all flush/bubble=0, pc_src=0. The pipeline freezes and a pending branch is deferred.
  2. br_taken:
     - pc_src=1 and pc_write=1;
     - ifid_flush, idex_flush and exmem_flush=1;
     - other write enables=1.
     - A simultaneous lu_hazard is ignored (wrong path).
  3. lu_hazard: pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1, exmem_write=1. Latency is exactly 1 stall cycle; the bubble clears the hazard on the next cycle.
  4. Otherwise all write enables=1, flush/bubble=0, pc_src=0.
- ERROR state: all write enables=0, flush/bubble/pc_src=0, mem_err=1. The design exits ERROR only by reset.
- Transitions:
  - RUN -> MEM_WAIT on mem_stall.
  - MEM_WAIT -> RUN when dmem_ready=1. That cycle uses normal priority, so the pipeline advances.
  - MEM_WAIT -> ERROR when mem_stall and timer == TIMEOUT-1.
- Timer:
  - Cleared in any cycle with mem_stall=0.
  - Increments on each mem_stall cycle, including the first cycle in RUN.
  - The TIMEOUT-th consecutive not-ready cycle moves the state to ERROR at the following edge.
- Counters, each saturating at all-ones with no wrap:
  - stall_cnt +1 per cycle where priority 3 applies;
  - flush_cnt +1 per cycle where priority 2 applies;
  - wait_cnt +1 per mem_stall cycle.
- Reset mid-wait or mid-error returns the design to RUN with zero counters on that edge.

Test Plan:
- Reset held 2 cycles, then released with no hazards -> every cycle: pc_write=ifid_write=idex_write=exmem_write=1; all counters 0.
- idex_memread=1, idex_rd=5, ifid_rs2=5 for one cycle -> pc_write=0, ifid_write=0, idex_bubble=1 that cycle; stall_cnt=1. Same stimulus with idex_rd=0 -> no stall.
- exmem_branch=1, exmem_zero=1 together with the load-use pattern above -> pc_src=1 and all three flushes=1 that cycle; idex_bubble=0; flush_cnt=1, stall_cnt=0.
- exmem_memread=1, dmem_ready=0 for 3 cycles then 1 -> writes frozen for 3 cycles, advance on the 4th; state returns to RUN; wait_cnt=3; mem_err=0.
- exmem_memwrite=1, dmem_ready=0 for 16 cycles (TIMEOUT=16) -> ERROR after the 16th edge; mem_err=1; dmem_ready=1 afterwards has no effect. reset=0 for one edge -> RUN, mem_err=0.
- Saturation check with CNT_W=4: 20 load-use stalls -> stall_cnt holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core.
// Load-use stalls, branch flush, dmem waits, perf counters.
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             idex_memread,
   input  logic [4:0]       idex_rd,
   input  logic [4:0]       ifid_rs1,
   input  logic [4:0]       ifid_rs2,
   input  logic             exmem_branch,
   input  logic             exmem_zero,
   input  logic             exmem_memread,
   input  logic             exmem_memwrite,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             pc_src,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] wait_cnt
);

   typedef enum logic [1:0] {
      S_RUN,
      S_WAIT,
      S_ERR
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [TO_W-1:0] timer;

   logic mem_req;
   logic mem_stall;
   logic br_taken;
   logic lu_hazard;
   logic active;
   logic do_stall;
   logic do_flush;
   logic do_wait;
   logic to_hit;

   assign mem_req   = exmem_memread | exmem_memwrite;
   assign mem_stall = mem_req & ~dmem_ready;
   assign br_taken  = exmem_branch & exmem_zero;
   assign lu_hazard = idex_memread
                    & (idex_rd != 5'd0)
                    & ((idex_rd == ifid_rs1)
                    |  (idex_rd == ifid_rs2));

   assign active  = reset & (state != S_ERR);
   assign do_wait = active & mem_stall;
   assign to_hit  = (timer == TO_W'(TIMEOUT - 1));
   assign mem_err = (state == S_ERR);

   // Control outputs by hazard priority; all low in reset/error.
   always_comb begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pc_src      = 1'b0;
      do_stall    = 1'b0;
      do_flush    = 1'b0;
      if (active) begin
         priority case (1'b1)
            mem_stall: begin
            end
            br_taken: begin
               do_flush    = 1'b1;
               pc_src      = 1'b1;
               pc_write    = 1'b1;
               ifid_write  = 1'b1;
               idex_write  = 1'b1;
               exmem_write = 1'b1;
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
            end
            lu_hazard: begin
               do_stall    = 1'b1;
               idex_bubble = 1'b1;
               idex_write  = 1'b1;
               exmem_write = 1'b1;
            end
            default: begin
               pc_write    = 1'b1;
               ifid_write  = 1'b1;
               idex_write  = 1'b1;
               exmem_write = 1'b1;
            end
         endcase
      end
   end

   // Next state: wait on memory, trip to error on timeout.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_RUN: begin
            if (mem_stall)
               state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (dmem_ready)
               state_nx = S_RUN;
            else if (mem_stall && to_hit)
               state_nx = S_ERR;
         end
         S_ERR: state_nx = S_ERR;
         default: state_nx = S_RUN;
      endcase
   end

   // State, wait timer and saturating counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_RUN;
         timer     <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         state <= state_nx;
         if (do_wait)
            timer <= timer + TO_W'(1);
         else
            timer <= '0;
         if (do_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (do_flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
         if (do_wait && (wait_cnt != '1))
            wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl.
// Vector table plus timeout, reset and saturation sequences.
module tb_pipeline_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       idex_memread;
   logic [4:0] idex_rd;
   logic [4:0] ifid_rs1;
   logic [4:0] ifid_rs2;
   logic       exmem_branch;
   logic       exmem_zero;
   logic       exmem_memread;
   logic       exmem_memwrite;
   logic       dmem_ready;

   logic        pc_write, ifid_write, idex_write, exmem_write;
   logic        idex_bubble, ifid_flush, idex_flush, exmem_flush;
   logic        pc_src, mem_err;
   logic [15:0] stall_cnt, flush_cnt, wait_cnt;

   logic        pc_write4, ifid_write4, idex_write4, exmem_write4;
   logic        idex_bubble4, ifid_flush4, idex_flush4, exmem_flush4;
   logic        pc_src4, mem_err4;
   logic [3:0]  stall_cnt4, flush_cnt4, wait_cnt4;

   logic [8:0]  ctl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign ctl = {pc_write, ifid_write, idex_write, exmem_write,
                 idex_bubble, ifid_flush, idex_flush, exmem_flush,
                 pc_src};

   pipeline_hazard_ctrl #(.TIMEOUT(16), .TO_W(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .idex_memread(idex_memread), .idex_rd(idex_rd),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
      .exmem_memread(exmem_memread),
      .exmem_memwrite(exmem_memwrite),
      .dmem_ready(dmem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write),
      .idex_write(idex_write), .exmem_write(exmem_write),
      .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_flush(exmem_flush),
      .pc_src(pc_src), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
      .wait_cnt(wait_cnt)
   );

   pipeline_hazard_ctrl #(.TIMEOUT(16), .TO_W(8), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .idex_memread(idex_memread), .idex_rd(idex_rd),
      .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
      .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
      .exmem_memread(exmem_memread),
      .exmem_memwrite(exmem_memwrite),
      .dmem_ready(dmem_ready),
      .pc_write(pc_write4), .ifid_write(ifid_write4),
      .idex_write(idex_write4), .exmem_write(exmem_write4),
      .idex_bubble(idex_bubble4), .ifid_flush(ifid_flush4),
      .idex_flush(idex_flush4), .exmem_flush(exmem_flush4),
      .pc_src(pc_src4), .mem_err(mem_err4),
      .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4),
      .wait_cnt(wait_cnt4)
   );

   typedef struct {
      logic       mr;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       br;
      logic       zr;
      logic       emr;
      logic       emw;
      logic       rdy;
      logic [8:0] ctl;
      int         sc;
      int         fc;
      int         wc;
   } vec_t;

   localparam logic [8:0] NORM = 9'b1111_0000_0;
   localparam logic [8:0] FRZ  = 9'b0000_0000_0;
   localparam logic [8:0] LU   = 9'b0011_1000_0;
   localparam logic [8:0] BR   = 9'b1111_0111_1;

   localparam int NV = 12;
   vec_t tbl [NV];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      idex_memread   = v.mr;
      idex_rd        = v.rd;
      ifid_rs1       = v.rs1;
      ifid_rs2       = v.rs2;
      exmem_branch   = v.br;
      exmem_zero     = v.zr;
      exmem_memread  = v.emr;
      exmem_memwrite = v.emw;
      dmem_ready     = v.rdy;
   endtask

   function automatic vec_t mk(
      input logic mr, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic br, input logic zr,
      input logic emr, input logic emw, input logic rdy,
      input logic [8:0] c, input int sc, input int fc,
      input int wc);
      vec_t v;
      v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.br = br; v.zr = zr; v.emr = emr; v.emw = emw;
      v.rdy = rdy; v.ctl = c;
      v.sc = sc; v.fc = fc; v.wc = wc;
      return v;
   endfunction

   initial begin
      vec_t idle;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);

      tbl[0]  = mk(0, 5'd0, 5'd1, 5'd2, 0, 0, 0, 0, 0,
                   NORM, 0, 0, 0);
      tbl[1]  = mk(1, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, 0,
                   LU,   1, 0, 0);
      tbl[2]  = mk(0, 5'd5, 5'd1, 5'd5, 0, 0, 0, 0, 0,
                   NORM, 1, 0, 0);
      tbl[3]  = mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0,
                   NORM, 1, 0, 0);
      tbl[4]  = mk(1, 5'd7, 5'd7, 5'd3, 0, 0, 0, 0, 0,
                   LU,   2, 0, 0);
      tbl[5]  = mk(1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0,
                   BR,   2, 1, 0);
      tbl[6]  = mk(0, 5'd0, 5'd1, 5'd2, 1, 0, 0, 0, 0,
                   NORM, 2, 1, 0);
      tbl[7]  = mk(0, 5'd0, 5'd1, 5'd2, 0, 0, 1, 0, 0,
                   FRZ,  2, 1, 1);
      tbl[8]  = mk(1, 5'd5, 5'd5, 5'd2, 0, 0, 1, 0, 0,
                   FRZ,  2, 1, 2);
      tbl[9]  = mk(0, 5'd0, 5'd1, 5'd2, 1, 1, 1, 0, 0,
                   FRZ,  2, 1, 3);
      tbl[10] = mk(0, 5'd0, 5'd1, 5'd2, 1, 1, 1, 0, 1,
                   BR,   2, 2, 3);
      tbl[11] = mk(1, 5'd9, 5'd9, 5'd9, 0, 0, 0, 1, 1,
                   LU,   3, 2, 3);

      reset = 1'b0;
      drive(idle);
      #1;
      step();
      chk("rst_ctl", 32'(ctl), 32'(FRZ));
      step();
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_flush", 32'(flush_cnt), 0);
      chk("rst_wait", 32'(wait_cnt), 0);
      chk("rst_err", 32'(mem_err), 0);
      reset = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(tbl[i]);
         #3;
         chk($sformatf("v%0d_ctl", i), 32'(ctl), 32'(tbl[i].ctl));
         chk($sformatf("v%0d_err", i), 32'(mem_err), 0);
         step();
         chk($sformatf("v%0d_sc", i), 32'(stall_cnt), tbl[i].sc);
         chk($sformatf("v%0d_fc", i), 32'(flush_cnt), tbl[i].fc);
         chk($sformatf("v%0d_wc", i), 32'(wait_cnt), tbl[i].wc);
      end

      drive(idle);
      exmem_memwrite = 1'b1;
      dmem_ready     = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         #3;
         chk($sformatf("to%0d_ctl", i), 32'(ctl), 32'(FRZ));
         chk($sformatf("to%0d_err", i), 32'(mem_err), 0);
         step();
      end
      chk("to_err_set", 32'(mem_err), 1);
      chk("to_wait", 32'(wait_cnt), 3 + 16);
      chk("to_wait4_sat", 32'(wait_cnt4), 15);
      chk("to_err4", 32'(mem_err4), 1);

      drive(idle);
      dmem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         chk("err_ctl", 32'(ctl), 32'(FRZ));
         step();
         chk("err_sticky", 32'(mem_err), 1);
      end
      chk("err_stall_hold", 32'(stall_cnt), 3);

      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("rst2_err", 32'(mem_err), 0);
      chk("rst2_wait", 32'(wait_cnt), 0);
      chk("rst2_stall", 32'(stall_cnt), 0);
      #3;
      chk("rst2_ctl", 32'(ctl), 32'(NORM));
      step();

      exmem_memread = 1'b1;
      dmem_ready    = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      drive(idle);
      #3;
      chk("rstw_ctl", 32'(ctl), 32'(NORM));
      chk("rstw_wait", 32'(wait_cnt), 0);
      step();

      idex_memread = 1'b1;
      idex_rd      = 5'd12;
      ifid_rs1     = 5'd12;
      for (int i = 1; i <= 20; i++) begin
         step();
         chk($sformatf("sat%0d_16", i), 32'(stall_cnt), i);
         chk($sformatf("sat%0d_4", i), 32'(stall_cnt4),
             (i > 15) ? 15 : i);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
